// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor controller.
// A single 1-bit full-adder cell is time-shared across a WIDTH-bit operation,
// LSB first, with the carry held in a flip-flop between bits.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow flag).
// With the macro undefined, ovf is tied to 0 and no capture flop is built.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum_out;
    logic               r_cout;

    logic               w_cell_s;
    logic               w_cell_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // Shared 1-bit full-adder cell fed by the operand LSBs and the carry flop
    assign w_cell_s   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cell_c   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // Result after the current bit is shifted in at the MSB
    assign w_res_next = {w_cell_s, r_res[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, FIN always lasts one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand load, per-bit shifting and result capture. The output registers
    // are loaded on the RUN->FIN edge so they are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum_out <= '0;
            r_cout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= sub ? ~b_in : b_in;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cell_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum_out <= w_res_next;
                        r_cout    <= w_cell_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_cin_msb;

    // Capture the carry into the MSB during the final RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cin_msb <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_cin_msb <= r_carry;
        end
    end

    // Both flops hold until the next completion, so ovf holds with sum_out
    assign ovf = r_cin_msb ^ r_cout;
`else
    assign ovf = 1'b0;
`endif

    assign busy    = (r_state == RUN);
    assign done    = (r_state == FIN);
    assign sum_out = r_sum_out;
    assign cout    = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed vectors, scoreboard queue filled by
// the stimulus side and drained by a monitor whenever done is high.
module tb_serial_add_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         ovf;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare one expected result per done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".sum"},  32'(sum_out), 32'(e.sum));
                chk({e.name, ".cout"}, 32'(cout),    32'(e.c));
                chk({e.name, ".ovf"},  32'(ovf),     32'(e.o));
                $display("op %s: sum_out=%02h cout=%0d ovf=%0d", e.name, sum_out, cout, ovf);
            end
        end
    end

    // One operation: start at cycle 0, busy for cycles 1..W, done at W+1.
    // inj > 0 pulses start with different operands at that RUN cycle.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] es, input logic ec,
                          input logic eo, input int inj);
        exp_t e;
        int   d0;
        e.sum = es; e.c = ec; e.o = eo; e.name = nm;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; sub = s;
        sb.push_back(e);
        d0 = n_done;
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = a ^ b; sub = ~s;
        for (int n = 1; n <= W + 1; n++) begin
            if (n > 1) @(negedge clk);
            if (n == inj) begin
                start = 1'b1; a_in = 8'hA5; b_in = 8'h5A; sub = ~s;
            end else if (n == inj + 1) begin
                start = 1'b0;
            end
            chk({nm, ".busy"}, 32'(busy), 32'(n <= W));
            chk({nm, ".done"}, 32'(done), 32'(n == W + 1));
        end
        @(negedge clk);
        chk({nm, ".idle_after"}, 32'({busy, done}), 32'd0);
        chk({nm, ".done_count"}, 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        int pulses;
        int t[$];
        int d0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk("reset.outs", 32'({busy, done, sum_out, cout, ovf}), 32'd0);
        rst_n = 1'b1;

        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON, 0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
        run_op("sub_20_10", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, OVF_ON, 0);
        run_op("ign_start", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 3);

        // Reset in the middle of an operation: nothing is pushed for it
        @(negedge clk);
        start = 1'b1; a_in = 8'h01; b_in = 8'h01; sub = 1'b0;
        d0 = n_done;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst.outs", 32'({busy, done, sum_out, cout, ovf}), 32'd0);
        $display("op mid_reset: outputs=%0h", {busy, done, sum_out, cout, ovf});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst.no_done", 32'(n_done - d0), 32'd0);
        run_op("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        // Start held high: three back-to-back operations
        @(negedge clk);
        start = 1'b1; a_in = 8'h12; b_in = 8'h34; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.sum = 8'h46; e.c = 1'b0; e.o = 1'b0; e.name = "b2b";
            sb.push_back(e);
        end
        pulses = 0;
        for (int k = 0; k < 50 && pulses < 3; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                t.push_back(cyc);
            end
            if (pulses > 0) chk("b2b.stable", 32'(sum_out), 32'h46);
            if (pulses == 3) start = 1'b0;
        end
        start = 1'b0;
        chk("b2b.pulses", 32'(pulses), 32'd3);
        if (t.size() == 3) begin
            chk("b2b.gap1", 32'(t[1] - t[0]), 32'd10);
            chk("b2b.gap2", 32'(t[2] - t[1]), 32'd10);
        end
        repeat (14) @(negedge clk);
        chk("b2b.no_extra", 32'(busy), 32'd0);
        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
